grid_port_scheduler: RTL and testbench
======================================

# grid_port_scheduler

Owns the single read/write port of the fluid-grid BRAM (9×8-bit D2Q9 densities per cell, 205×154 cells) and time-shares it between the display pixel path, the lattice update engine and the barrier-paint path. The display gets the port every cycle of the active grid window. Blanking cycles are arbitrated round-robin between sim and paint. The block also sequences simulation steps: one step start per N frames, never while a step is still running.

## Interface
- BRAM_DEPTH, 31570, grid cells (= GRID_W·GRID_H)
- GRID_W, 205, cells per row
- GRID_H, 154, cell rows
- PIX_SHIFT, 2, log2 of screen pixels per cell edge
- RD_LAT, 2, BRAM read latency in cycles (1..4)
- FRAMES_PER_STEP, 1, frames between step starts (1..15)
- AW, $clog2(BRAM_DEPTH), address width (derived localparam)

Ports:
- pixel_clk_in  in  1  sole clock
- rst_in  in  1  reset; asynchronous, active-low
- hcount_in  in  11  video h counter
- vcount_in  in  10  video v counter
- disp_addr_in  in  AW  display read address
- sim_req_in  in  1  sim engine access request
- sim_we_in  in  1  sim request is a write
- sim_addr_in  in  AW  sim address
- sim_data_in  in  72  sim write data ([8:0][7:0])
- sim_gnt_out  out  1  sim access issued this cycle
- sim_rvalid_out  out  1  bram_dout valid for a sim read
- step_start_out  out  1  one-cycle pulse: begin a lattice step
- step_done_in  in  1  one-cycle pulse from sim engine: step finished
- paint_req_in  in  1  barrier write request
- paint_addr_in  in  AW  barrier cell
- paint_gnt_out  out  1  paint write issued this cycle
- disp_rvalid_out  out  1  bram_dout valid for display
- bram_addr_out  out  AW  port address (registered)
- bram_we_out  out  1  port write enable (registered)
- bram_din_out  out  72  port write data (registered)

## Operation
- Display window: (hcount_in>>PIX_SHIFT) < GRID_W and (vcount_in>>PIX_SHIFT) < GRID_H. Inside it, the port carries disp_addr_in and we=0. No other grant is issued.
- Outside the window, the cycle is free:
  - Sim only requesting → sim is granted.
  - Paint only requesting → paint is granted.
  - Both requesting → grant the one not granted on the last contested free cycle. The pointer resets to favour sim.
- Paint write data is all bytes 8'hFF; the barrier marker is byte[5]=255.
- Paint is granted only while step FSM is IDLE. This prevents tearing a step.
- Requesters hold req/addr/data until they see a grant. Deasserting before grant is allowed and drops the request.
- Any address ≥ BRAM_DEPTH from sim or paint is granted but issued with we=0. The display still receives its address unchanged.
- Step FSM:
  - IDLE: at frame start (hcount_in==0 and vcount_in==0), increment the frame counter. When it reaches FRAMES_PER_STEP, pulse step_start_out, clear the counter and go to RUN.
  - RUN: on step_done_in go to IDLE. A frame start seen in RUN still counts, saturating at FRAMES_PER_STEP.
  - step_done_in in IDLE is ignored.
  - Simultaneous frame start and step_done_in in RUN: go to IDLE; the new start is issued at the next frame start.
- Read-valid pipeline: an RD_LAT-deep shift of {owner, is_read} tags. disp_rvalid_out / sim_rvalid_out assert exactly RD_LAT cycles after the corresponding port cycle. Writes produce no valid.

## Timing
- Grants are combinational from the current inputs. bram_* outputs are registered, so the BRAM sees the access 1 cycle after the grant. Valid asserts RD_LAT cycles after bram_addr_out changes.
- The display read path therefore totals 1+RD_LAT cycles. The upstream pixel pipeline compensates.
- Reset values (asynchronous, immediate):
  - Outputs: bram_addr_out=0, bram_we_out=0, bram_din_out=0; all gnt, valid and step_start outputs 0.
  - Internal: FSM=IDLE, frame counter=0, tag pipeline cleared, round-robin pointer favours sim.
- Reset mid-step: the engine is expected to be reset with the same rst_in. After release, the first step starts on the FRAMES_PER_STEP-th frame start.
- Frame counter is 4 bits and never wraps.

## Structure
- Package grid_pkg holds:
  - GRID_W, GRID_H, BRAM_DEPTH, PIX_SHIFT.
  - Typedef cell_t = logic [8:0][7:0].
  - Enum owner_t {OWN_NONE, OWN_DISP, OWN_SIM, OWN_PAINT}.
  - Enum step_state_t {ST_IDLE, ST_RUN}.
  - BARRIER_CELL constant.
- One sub-module: rd_tag_pipe, a parameterised RD_LAT-deep shift of owner_t with async active-low reset.

## Test plan
- Sweep a full frame with sim_req_in held high → sim_gnt_out is 0 for every cycle with hcount<820 and vcount<616, and 1 on every other cycle.
- Blanking cycle, sim read at address 100 → bram_addr_out=100 one cycle later; sim_rvalid_out high exactly 1+RD_LAT=3 cycles after the grant.
- Sim and paint both requesting for 6 free cycles with FSM IDLE → grants alternate sim, paint, sim, paint, sim, paint.
- FRAMES_PER_STEP=3, step_done_in returned 10 cycles after each start → step_start_out pulses on frame starts 3, 6 and 9 only.
- step_done_in withheld for 5 frames → no further step_start_out; the pulse comes on the first frame start after done, then every 3.
- Paint at address 31570 during blanking → paint_gnt_out=1, bram_we_out stays 0.
- rst_in low during RUN and a pending read → all outputs 0 immediately; no stale rvalid after release.

Source files
------------

// File: rtl/grid_port_scheduler_pkg.sv
// grid_pkg: shared geometry, cell payload type, port-owner and step-state
// enums, and the barrier write pattern for the fluid-grid BRAM port.
package grid_pkg;

  localparam int unsigned GRID_W     = 205;
  localparam int unsigned GRID_H     = 154;
  localparam int unsigned BRAM_DEPTH = GRID_W * GRID_H;
  localparam int unsigned PIX_SHIFT  = 2;
  localparam int unsigned AW         = $clog2(BRAM_DEPTH);
  localparam int unsigned HC_W       = 11;
  localparam int unsigned VC_W       = 10;
  localparam int unsigned FCNT_W     = 4;

  // Nine D2Q9 densities, one byte each.
  typedef logic [8:0][7:0] cell_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_SIM,
    OWN_PAINT
  } owner_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } step_state_t;

  // Every byte saturated; the engine keys barriers off byte[5] == 8'hFF.
  localparam cell_t BARRIER_CELL = {9{8'hFF}};

  // True when the address falls inside the physical grid.
  function automatic logic addr_in_grid(input logic [AW-1:0] addr);
    return 32'(addr) < BRAM_DEPTH;
  endfunction

endpackage

// File: rtl/grid_port_scheduler_if.sv
// grid_port_scheduler_if: sim / paint request-grant handshakes and the
// registered BRAM port bundle.
//   slave  : scheduler side (takes requests, drives grants/valids/port)
//   master : requester / memory side
interface grid_port_scheduler_if;
  import grid_pkg::*;

  logic          sim_req_in;
  logic          sim_we_in;
  logic [AW-1:0] sim_addr_in;
  cell_t         sim_data_in;
  logic          sim_gnt_out;
  logic          sim_rvalid_out;

  logic          paint_req_in;
  logic [AW-1:0] paint_addr_in;
  logic          paint_gnt_out;

  logic [AW-1:0] bram_addr_out;
  logic          bram_we_out;
  cell_t         bram_din_out;

  modport slave (
    input  sim_req_in, sim_we_in, sim_addr_in, sim_data_in,
    input  paint_req_in, paint_addr_in,
    output sim_gnt_out, sim_rvalid_out, paint_gnt_out,
    output bram_addr_out, bram_we_out, bram_din_out
  );

  modport master (
    output sim_req_in, sim_we_in, sim_addr_in, sim_data_in,
    output paint_req_in, paint_addr_in,
    input  sim_gnt_out, sim_rvalid_out, paint_gnt_out,
    input  bram_addr_out, bram_we_out, bram_din_out
  );

endinterface

// File: rtl/grid_port_scheduler_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of port-owner tags, so read data
// returning from the BRAM can be attributed to the requester that issued it.
//   pixel_clk_in : clock
//   rst_in       : async active-low reset, clears every stage to OWN_NONE
//   tag_in       : owner of the access issued this cycle
//   tag_out      : owner of the access issued DEPTH cycles ago
module rd_tag_pipe
  import grid_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   pixel_clk_in,
  input  logic   rst_in,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t pipe_q [DEPTH];

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= OWN_NONE;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/grid_port_scheduler.sv
// grid_port_scheduler: owns the single fluid-grid BRAM port. The display
// takes every cycle of the active grid window; blanking cycles go to the
// sim engine or the barrier painter, round-robin when both ask. Also paces
// lattice steps: one step start per FRAMES_PER_STEP frame starts, never
// while a step is still running.
//   pixel_clk_in / rst_in      : clock, async active-low reset
//   hcount_in / vcount_in      : video raster position
//   disp_addr_in               : display read address
//   step_start_out / _done_in  : step handshake with the sim engine
//   disp_rvalid_out            : bram_dout carries display read data
//   bus (slave)                : sim/paint handshakes, registered BRAM port
// Grants are combinational; the port itself is registered one cycle later
// and read valids follow RD_LAT cycles after that.
module grid_port_scheduler
  import grid_pkg::*;
#(
  parameter int unsigned RD_LAT          = 2,
  parameter int unsigned FRAMES_PER_STEP = 1
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic [HC_W-1:0]        hcount_in,
  input  logic [VC_W-1:0]        vcount_in,
  input  logic [AW-1:0]          disp_addr_in,
  input  logic                   step_done_in,
  output logic                   step_start_out,
  output logic                   disp_rvalid_out,
  grid_port_scheduler_if.slave   bus
);

  localparam logic [FCNT_W-1:0] FPS_CNT = FCNT_W'(FRAMES_PER_STEP);

  // Raster classification.
  logic in_window_c;
  logic frame_start_c;

  assign in_window_c   = (32'(hcount_in >> PIX_SHIFT) < GRID_W) &&
                         (32'(vcount_in >> PIX_SHIFT) < GRID_H);
  assign frame_start_c = (hcount_in == '0) && (vcount_in == '0);

  // Step sequencer state.
  step_state_t         state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                start_d;

  // Arbitration.
  logic rr_sim_q;
  logic paint_ok_c;
  logic contest_c;
  logic sim_gnt_c;
  logic paint_gnt_c;

  // Painting is held off for the whole step so a step never sees a
  // half-painted barrier.
  assign paint_ok_c  = bus.paint_req_in && (state_q == ST_IDLE);
  assign contest_c   = !in_window_c && bus.sim_req_in && paint_ok_c;
  // Gated with reset so grants drop as soon as reset asserts.
  assign sim_gnt_c   = rst_in && !in_window_c && bus.sim_req_in &&
                       (!paint_ok_c || rr_sim_q);
  assign paint_gnt_c = rst_in && !in_window_c && paint_ok_c &&
                       (!bus.sim_req_in || !rr_sim_q);

  assign bus.sim_gnt_out   = sim_gnt_c;
  assign bus.paint_gnt_out = paint_gnt_c;

  // Port issue mux and read-owner tag for the access being issued.
  logic [AW-1:0] bram_addr_q, addr_d;
  logic          bram_we_q, we_d;
  cell_t         bram_din_q, din_d;
  owner_t        tag_d;

  always_comb begin
    addr_d = bram_addr_q;
    we_d   = 1'b0;
    din_d  = bram_din_q;
    tag_d  = OWN_NONE;
    if (in_window_c) begin
      addr_d = disp_addr_in;
      tag_d  = OWN_DISP;
    end else if (sim_gnt_c) begin
      addr_d = bus.sim_addr_in;
      we_d   = bus.sim_we_in && addr_in_grid(bus.sim_addr_in);
      din_d  = bus.sim_data_in;
      tag_d  = bus.sim_we_in ? OWN_NONE : OWN_SIM;
    end else if (paint_gnt_c) begin
      addr_d = bus.paint_addr_in;
      we_d   = addr_in_grid(bus.paint_addr_in);
      din_d  = BARRIER_CELL;
    end
  end

  // Step sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start_c) begin
          // Counter may already sit at the target if frames arrived
          // during the previous step.
          if ((5'(fcnt_q) + 5'd1) >= 5'(FPS_CNT)) begin
            start_d = 1'b1;
            fcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (frame_start_c && (fcnt_q < FPS_CNT)) fcnt_d = fcnt_q + FCNT_W'(1);
        if (step_done_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state: sequencer, round-robin pointer, BRAM port.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= ST_IDLE;
      fcnt_q         <= '0;
      step_start_out <= 1'b0;
      rr_sim_q       <= 1'b1;
      bram_addr_q    <= '0;
      bram_we_q      <= 1'b0;
      bram_din_q     <= '0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      step_start_out <= start_d;
      if (contest_c) rr_sim_q <= !sim_gnt_c;
      bram_addr_q    <= addr_d;
      bram_we_q      <= we_d;
      bram_din_q     <= din_d;
    end
  end

  assign bus.bram_addr_out = bram_addr_q;
  assign bus.bram_we_out   = bram_we_q;
  assign bus.bram_din_out  = bram_din_q;

  // Read-owner tags travel RD_LAT cycles, then one more register stage
  // lines valid up with data leaving the BRAM.
  owner_t tag_tail;
  logic   sim_rvalid_q;

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .tag_in       (tag_d),
    .tag_out      (tag_tail)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      disp_rvalid_out <= 1'b0;
      sim_rvalid_q    <= 1'b0;
    end else begin
      disp_rvalid_out <= (tag_tail == OWN_DISP);
      sim_rvalid_q    <= (tag_tail == OWN_SIM);
    end
  end

  assign bus.sim_rvalid_out = sim_rvalid_q;

endmodule

// File: tb/tb_grid_port_scheduler.sv
// Bench for grid_port_scheduler: directed scenarios plus random traffic,
// checked every cycle against a pixel-level reference model.
module tb_grid_port_scheduler;
  import grid_pkg::*;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned FPS    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic [AW-1:0]     disp_addr;
  logic              step_done;
  logic              step_start;
  logic              disp_rvalid;

  grid_port_scheduler_if bus ();

  grid_port_scheduler #(
    .RD_LAT          (RD_LAT),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .hcount_in       (hc),
    .vcount_in       (vc),
    .disp_addr_in    (disp_addr),
    .step_done_in    (step_done),
    .step_start_out  (step_start),
    .disp_rvalid_out (disp_rvalid),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  bit          m_sim_turn;   // sim wins the next contested free cycle
  bit          m_running;
  int unsigned m_frames;
  int          rdq[$];       // 0 none, 1 display read, 2 sim read

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    hc = 11'd900; vc = 10'd100; disp_addr = '0; step_done = 1'b0;
    bus.sim_req_in = 1'b0; bus.sim_we_in = 1'b0; bus.sim_addr_in = '0;
    bus.sim_data_in = '0; bus.paint_req_in = 1'b0; bus.paint_addr_in = '0;
  endtask

  task automatic model_reset();
    m_sim_turn = 1'b1; m_running = 1'b0; m_frames = 0;
    rdq.delete();
    for (int i = 0; i < int'(RD_LAT); i++) rdq.push_back(0);
  endtask

  // One clock cycle; entered and left at a falling edge with inputs set.
  task automatic tick();
    bit inwin, paint_ok, sreq, e_sg, e_pg, fs, e_start, issued;
    logic [AW-1:0] e_addr;
    logic e_we;
    cell_t e_din;
    int own;
    #1;
    inwin    = (hc < 820) && (vc < 616);
    paint_ok = bus.paint_req_in && !m_running;
    sreq     = bus.sim_req_in;
    e_sg     = !inwin && sreq && (!paint_ok || m_sim_turn);
    e_pg     = !inwin && paint_ok && (!sreq || !m_sim_turn);
    chk("sim_gnt", 96'(bus.sim_gnt_out), 96'(e_sg));
    chk("paint_gnt", 96'(bus.paint_gnt_out), 96'(e_pg));
    issued = 1'b1; own = 0; e_addr = '0; e_we = 1'b0; e_din = '0;
    if (inwin) begin
      e_addr = disp_addr; own = 1;
    end else if (e_sg) begin
      e_addr = bus.sim_addr_in; e_din = bus.sim_data_in;
      e_we = bus.sim_we_in && (int'(bus.sim_addr_in) < 31570);
      own = bus.sim_we_in ? 0 : 2;
    end else if (e_pg) begin
      e_addr = bus.paint_addr_in; e_din = {9{8'hFF}};
      e_we = int'(bus.paint_addr_in) < 31570;
    end else begin
      issued = 1'b0;
    end
    rdq.push_back(own);
    fs = (hc == 0) && (vc == 0);
    e_start = 1'b0;
    if (m_running) begin
      if (fs && m_frames < FPS) m_frames++;
      if (step_done) m_running = 1'b0;
    end else if (fs) begin
      m_frames++;
      if (m_frames >= FPS) begin
        e_start = 1'b1; m_frames = 0; m_running = 1'b1;
      end
    end
    if (!inwin && sreq && paint_ok) m_sim_turn = !e_sg;
    @(posedge clk); #1;
    if (issued) begin
      chk("bram_addr", 96'(bus.bram_addr_out), 96'(e_addr));
      chk("bram_we", 96'(bus.bram_we_out), 96'(e_we));
      if (!inwin) chk("bram_din", 96'(bus.bram_din_out), 96'(e_din));
    end else begin
      chk("bram_we_idle", 96'(bus.bram_we_out), 96'(1'b0));
    end
    chk("step_start", 96'(step_start), 96'(e_start));
    chk("disp_rvalid", 96'(disp_rvalid), 96'(rdq[0] == 1));
    chk("sim_rvalid", 96'(bus.sim_rvalid_out), 96'(rdq[0] == 2));
    void'(rdq.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, 96'(bus.bram_addr_out), 96'(0));
    chk({tag, "_we"}, 96'(bus.bram_we_out), 96'(0));
    chk({tag, "_din"}, 96'(bus.bram_din_out), 96'(0));
    chk({tag, "_sgnt"}, 96'(bus.sim_gnt_out), 96'(0));
    chk({tag, "_pgnt"}, 96'(bus.paint_gnt_out), 96'(0));
    chk({tag, "_srv"}, 96'(bus.sim_rvalid_out), 96'(0));
    chk({tag, "_drv"}, 96'(disp_rvalid), 96'(0));
    chk({tag, "_start"}, 96'(step_start), 96'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bh[6] = '{819, 820, 1, 0, 819, 820};
    int bv[6] = '{0, 0, 615, 616, 615, 616};
    logic [5:0] sseq, pseq;
    logic [15:0] mask;
    bit pending;

    // Reset state, with a blanking-cycle sim request held during reset.
    rst_n = 1'b0;
    idle_inputs();
    bus.sim_req_in = 1'b1;
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Window sweep: boundary corners, then random raster positions.
    for (int i = 0; i < 6; i++) begin
      hc = HC_W'(bh[i]); vc = VC_W'(bv[i]);
      bus.sim_req_in = 1'b1; bus.sim_addr_in = AW'($urandom_range(0, 31569));
      disp_addr = AW'($urandom_range(0, 31569));
      tick();
    end
    for (int i = 0; i < 200; i++) begin
      hc = HC_W'($urandom_range(1, 1343)); vc = VC_W'($urandom_range(0, 805));
      bus.sim_req_in = 1'b1; bus.sim_addr_in = AW'($urandom_range(0, 31569));
      disp_addr = AW'($urandom_range(0, 31569));
      tick();
    end

    // Blanking sim read at address 100, then let the valid drain out.
    do_reset();
    bus.sim_req_in = 1'b1; bus.sim_addr_in = AW'(100);
    tick();
    bus.sim_req_in = 1'b0;
    repeat (4) tick();

    // Contested free cycles alternate starting with sim.
    do_reset();
    bus.sim_req_in = 1'b1; bus.paint_req_in = 1'b1;
    bus.sim_addr_in = AW'(10); bus.paint_addr_in = AW'(20);
    for (int i = 0; i < 6; i++) begin
      #1;
      sseq[5-i] = bus.sim_gnt_out;
      pseq[5-i] = bus.paint_gnt_out;
      tick();
    end
    chk("alt_sim_seq", 96'(sseq), 96'(6'b101010));
    chk("alt_paint_seq", 96'(pseq), 96'(6'b010101));

    // Step cadence with done returned 10 cycles after each start.
    do_reset();
    mask = '0; pending = 1'b0;
    for (int f = 1; f <= 9; f++) begin
      hc = '0; vc = '0;
      tick();
      mask[f] = step_start;
      if (step_start) pending = 1'b1;
      hc = 11'd900; vc = 10'd100;
      for (int c = 1; c <= 14; c++) begin
        step_done = pending && (c == 10);
        if (step_done) pending = 1'b0;
        tick();
      end
      step_done = 1'b0;
    end
    chk("step_cadence", 96'(mask), 96'(16'b0000_0010_0100_1000));

    // Done withheld across frames 4..8; start resumes on frame 9, then 12.
    do_reset();
    mask = '0; pending = 1'b0;
    for (int f = 1; f <= 12; f++) begin
      hc = '0; vc = '0;
      tick();
      mask[f] = step_start;
      if (step_start) pending = 1'b1;
      hc = 11'd900; vc = 10'd100;
      for (int c = 1; c <= 12; c++) begin
        step_done = pending && (c == 10) && (f < 3 || f >= 8);
        if (step_done) pending = 1'b0;
        // Paint is refused while the step runs.
        bus.paint_req_in = (c == 5);
        bus.paint_addr_in = AW'(c);
        tick();
      end
      step_done = 1'b0; bus.paint_req_in = 1'b0;
    end
    chk("step_withheld", 96'(mask), 96'(16'b0001_0010_0000_1000));

    // Out-of-grid paint and sim write are granted but never written.
    do_reset();
    bus.paint_req_in = 1'b1; bus.paint_addr_in = AW'(31570);
    #1;
    chk("paint_oob_gnt", 96'(bus.paint_gnt_out), 96'(1));
    tick();
    chk("paint_oob_we", 96'(bus.bram_we_out), 96'(0));
    bus.paint_addr_in = AW'(31569);
    tick();
    chk("paint_last_we", 96'(bus.bram_we_out), 96'(1));
    chk("paint_last_din5", 96'(bus.bram_din_out[5]), 96'(8'hFF));
    bus.paint_req_in = 1'b0;
    bus.sim_req_in = 1'b1; bus.sim_we_in = 1'b1; bus.sim_addr_in = AW'(32767);
    bus.sim_data_in = 72'h0123456789ABCDEF42;
    tick();
    bus.sim_req_in = 1'b0; bus.sim_we_in = 1'b0;
    tick();

    // Reset during a running step with a sim read in flight.
    do_reset();
    for (int f = 0; f < int'(FPS); f++) begin
      hc = '0; vc = '0; tick();
      hc = 11'd900; vc = 10'd100; tick();
    end
    bus.sim_req_in = 1'b1; bus.sim_addr_in = AW'(77);
    tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.sim_req_in = 1'b0;
    bus.paint_req_in = 1'b1; bus.paint_addr_in = AW'(55);
    tick();
    bus.paint_req_in = 1'b0;
    repeat (5) tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        hc = '0; vc = '0;
      end else if ($urandom_range(0, 9) < 6) begin
        hc = HC_W'($urandom_range(820, 2047)); vc = VC_W'($urandom_range(0, 1023));
      end else begin
        hc = HC_W'($urandom_range(1, 2047)); vc = VC_W'($urandom_range(0, 1023));
      end
      disp_addr          = AW'($urandom);
      bus.sim_req_in     = 1'($urandom);
      bus.sim_we_in      = 1'($urandom);
      bus.sim_addr_in    = AW'($urandom);
      bus.sim_data_in    = 72'({$urandom, $urandom, $urandom});
      bus.paint_req_in   = 1'($urandom);
      bus.paint_addr_in  = AW'($urandom);
      step_done          = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
